// File: rtl/clock_time_set_rx_if.sv
// Serial "set time" link: inbound UART line plus the decoded time-load bundle
// handed to the timekeeping core.
interface clock_time_set_rx_if;
    logic       ena;
    logic       rx;
    logic       set_valid;
    logic [4:0] set_hh;
    logic [5:0] set_mm;
    logic [5:0] set_ss;
    logic       frame_err;
    logic       busy;

    modport master (
        output ena, rx,
        input  set_valid, set_hh, set_mm, set_ss, frame_err, busy
    );

    modport slave (
        input  ena, rx,
        output set_valid, set_hh, set_mm, set_ss, frame_err, busy
    );
endinterface

// File: rtl/clock_time_set_rx.sv
// UART 8N1 receiver plus 4-byte "set time" frame parser (sync, hh, mm, ss)
// with range check, inter-byte timeout and framing-error abort.
module clock_time_set_rx #(
    parameter int         CLKS_PER_BIT = 1042,
    parameter logic [7:0] SYNC_BYTE    = 8'h54,
    parameter int         TIMEOUT_BITS = 30
) (
    input logic               clk,
    input logic               rst_n,
    clock_time_set_rx_if.slave bus
);
    localparam int HALF_BIT  = CLKS_PER_BIT / 2;
    localparam int CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

    typedef enum logic [2:0] {
        B_IDLE  = 3'd0,
        B_START = 3'd1,
        B_DATA  = 3'd2,
        B_STOP  = 3'd3,
        B_BREAK = 3'd4
    } bit_state_e;

    typedef enum logic [1:0] {
        P_HUNT     = 2'd0,
        P_GOT_SYNC = 2'd1,
        P_GOT_H    = 2'd2,
        P_GOT_M    = 2'd3
    } parse_state_e;

    function automatic logic time_in_range(input logic [7:0] hh,
                                           input logic [7:0] mm,
                                           input logic [7:0] ss);
        return (hh < 8'd24) && (mm < 8'd60) && (ss < 8'd60);
    endfunction

    logic [1:0]       sync_q;
    logic             rxs_prev_q;
    bit_state_e       bit_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       byte_q;
    logic             byte_vld_q;

    parse_state_e     parse_q;
    logic [TMO_W-1:0] tmo_q;
    logic [7:0]       hh_byte_q;
    logic [7:0]       mm_byte_q;
    logic             set_valid_q;
    logic             frame_err_q;
    logic [4:0]       set_hh_q;
    logic [5:0]       set_mm_q;
    logic [5:0]       set_ss_q;

    logic rxs_s;
    logic cnt_done_s;
    logic stop_bad_s;

    assign rxs_s      = sync_q[1];
    assign cnt_done_s = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign stop_bad_s = (bit_q == B_STOP) && cnt_done_s && !rxs_s;

    // Line synchronizer and bit-level receive FSM; emits a one-cycle byte strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            rxs_prev_q <= 1'b1;
            bit_q      <= B_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            byte_q     <= 8'd0;
            byte_vld_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], bus.rx};
            rxs_prev_q <= rxs_s;
            if (!bus.ena) begin
                bit_q      <= B_IDLE;
                cnt_q      <= '0;
                bit_idx_q  <= 3'd0;
                byte_vld_q <= 1'b0;
            end else begin
                byte_vld_q <= 1'b0;
                case (bit_q)
                    B_IDLE: begin
                        cnt_q     <= '0;
                        bit_idx_q <= 3'd0;
                        if (rxs_prev_q && !rxs_s) begin
                            bit_q <= B_START;
                        end else begin
                            bit_q <= B_IDLE;
                        end
                    end
                    B_START: begin
                        if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                            cnt_q <= '0;
                            bit_q <= rxs_s ? B_IDLE : B_DATA;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    B_DATA: begin
                        if (cnt_done_s) begin
                            cnt_q   <= '0;
                            shift_q <= {rxs_s, shift_q[7:1]};
                            if (bit_idx_q == 3'd7) begin
                                bit_q <= B_STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    B_STOP: begin
                        if (cnt_done_s) begin
                            cnt_q <= '0;
                            if (rxs_s) begin
                                byte_q     <= shift_q;
                                byte_vld_q <= 1'b1;
                                bit_q      <= B_IDLE;
                            end else begin
                                bit_q <= B_BREAK;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    B_BREAK: begin
                        cnt_q <= '0;
                        if (rxs_s) begin
                            bit_q <= B_IDLE;
                        end else begin
                            bit_q <= B_BREAK;
                        end
                    end
                    default: begin
                        bit_q <= B_IDLE;
                        cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    // Frame parser with inter-byte timeout; owns the load pulse, error pulse and time outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parse_q     <= P_HUNT;
            tmo_q       <= '0;
            hh_byte_q   <= 8'd0;
            mm_byte_q   <= 8'd0;
            set_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            set_hh_q    <= 5'd0;
            set_mm_q    <= 6'd0;
            set_ss_q    <= 6'd0;
        end else if (!bus.ena) begin
            parse_q     <= P_HUNT;
            tmo_q       <= '0;
            set_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            set_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (stop_bad_s) begin
                frame_err_q <= 1'b1;
                parse_q     <= P_HUNT;
                tmo_q       <= '0;
            end else if (byte_vld_q) begin
                // The strobe cycle itself counts as the first elapsed cycle.
                tmo_q <= TMO_W'(1);
                case (parse_q)
                    P_HUNT: begin
                        parse_q <= (byte_q == SYNC_BYTE) ? P_GOT_SYNC : P_HUNT;
                    end
                    P_GOT_SYNC: begin
                        hh_byte_q <= byte_q;
                        parse_q   <= P_GOT_H;
                    end
                    P_GOT_H: begin
                        mm_byte_q <= byte_q;
                        parse_q   <= P_GOT_M;
                    end
                    P_GOT_M: begin
                        if (time_in_range(hh_byte_q, mm_byte_q, byte_q)) begin
                            set_valid_q <= 1'b1;
                            set_hh_q    <= hh_byte_q[4:0];
                            set_mm_q    <= mm_byte_q[5:0];
                            set_ss_q    <= byte_q[5:0];
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        parse_q <= P_HUNT;
                    end
                    default: begin
                        parse_q <= P_HUNT;
                    end
                endcase
            end else if ((parse_q != P_HUNT) && (bit_q == B_IDLE)) begin
                if (tmo_q == TMO_W'(TMO_LIMIT - 1)) begin
                    frame_err_q <= 1'b1;
                    parse_q     <= P_HUNT;
                    tmo_q       <= '0;
                end else begin
                    tmo_q <= tmo_q + TMO_W'(1);
                end
            end else begin
                tmo_q <= tmo_q;
            end
        end
    end

    assign bus.set_valid = set_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.set_hh    = set_hh_q;
    assign bus.set_mm    = set_mm_q;
    assign bus.set_ss    = set_ss_q;
    assign bus.busy      = (bit_q != B_IDLE) || (parse_q != P_HUNT);
endmodule

// File: doc/clock_time_set_rx.md
Name: clock_time_set_rx

Overview:
- UART receiver and frame parser that lets the clock be set over a serial line.
- The clock project transmits time; this block is the inbound direction: it accepts a 4-byte "set time" frame on one input pin.
- Each frame is range-checked; a valid frame is presented to the timekeeping core as one load pulse plus hours/minutes/seconds values.
- Sits between a ui_in bit and the time counters inside tt_um_ender_clock.

Parameters:
- CLKS_PER_BIT, 1042, clk cycles per UART bit (10 MHz / 9600 baud); must be >= 8.
- SYNC_BYTE, 8'h54, frame header byte ('T').
- TIMEOUT_BITS, 30, max idle gap in bit times between bytes of one frame before abort.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  block enable; low = synchronous clear of receive state.
- rx  input  1  UART line, 8N1, idle high, asynchronous to clk.
- set_valid  output  1  one-cycle pulse: a valid frame has been accepted.
- set_hh  output  5  hours 0..23, binary.
- set_mm  output  6  minutes 0..59, binary.
- set_ss  output  6  seconds 0..59, binary.
- frame_err  output  1  one-cycle pulse: frame aborted or rejected.
- busy  output  1  high while a byte or a frame is in progress.

Behaviour:
- Reset (async, rst_n=0): set_hh/mm/ss=0, set_valid=0, frame_err=0, busy=0, synchronizer flops=1, bit FSM=IDLE, parser=HUNT, all counters=0.
- rx passes through a 2-flop synchronizer, reset to 1. All logic uses the synchronized value rxs.

Bit FSM: IDLE, START, DATA, STOP, BREAK.
- IDLE: falling edge of rxs -> START, bit counter cleared.
- START: sample rxs CLKS_PER_BIT/2 cycles after the edge. rxs=1 -> false start, back to IDLE, no error. rxs=0 -> DATA.
- DATA: 8 samples spaced CLKS_PER_BIT apart, LSB first.
- STOP: sample one CLKS_PER_BIT later.
  - rxs=1 -> byte valid (internal strobe on the next cycle), go to IDLE.
  - rxs=0 -> framing error: frame_err pulse, parser forced to HUNT, bit FSM -> BREAK.
- BREAK: wait until rxs=1, then IDLE.

Parser FSM: HUNT, GOT_SYNC, GOT_H, GOT_M. It advances only on the byte strobe.
- HUNT: byte == SYNC_BYTE -> GOT_SYNC. Any other byte is ignored silently, no error.
- GOT_SYNC: latch hours byte -> GOT_H.
- GOT_H: latch minutes byte -> GOT_M.
- GOT_M: take seconds byte and check the full 8-bit values: hh<24, mm<60, ss<60.
  - All in range: on that strobe cycle set_valid=1 and set_hh/mm/ss load the truncated values in the same cycle. Outputs hold until the next valid frame.
  - Any out of range: frame_err=1, outputs unchanged.
  - Either way -> HUNT.
- Latency: set_valid rises exactly 1 clk after the stop-bit sample edge of byte 4.

Timeout:
- In GOT_SYNC/GOT_H/GOT_M a counter runs from each byte strobe.
- It is cleared by the next byte strobe, and frozen while the bit FSM is outside IDLE.
- On reaching TIMEOUT_BITS*CLKS_PER_BIT cycles: frame_err pulse, parser -> HUNT.

busy = (bit FSM != IDLE) or (parser != HUNT).

Other rules:
- set_valid and frame_err never assert in the same cycle.
- A SYNC_BYTE value arriving as hh/mm/ss is treated as data, not as a resync.
- ena=0 synchronously forces bit FSM IDLE, parser HUNT, counters 0, pulses 0. set_* hold their values. No frame_err is generated.
- Async reset mid-byte or mid-frame discards all partial data immediately.

Test Plan:
- All tests use CLKS_PER_BIT=16 for sim speed.
1. Reset: assert rst_n=0 in the middle of byte 2 of a frame -> all outputs 0, busy 0. After release with rx=1 for 200 cycles, no pulses.
2. Valid frame 54,0C,22,05 -> exactly one set_valid, 1 clk after the last stop sample. hh=12, mm=34, ss=5; busy drops the same cycle.
3. Out-of-range frame 54,18,00,00 -> one frame_err, no set_valid, outputs stay 12/34/5.
4. Garbage then frame 00,FF,54,17,3B,3B -> no frame_err, one set_valid with 23/59/59.
5. Second byte sent with stop bit=0 -> frame_err on the stop sample cycle. Next frame 54,01,02,03 -> set_valid with 1/2/3.
6. Timeout and glitch:
   - Send 54,05 then idle -> frame_err exactly 480 cycles after byte-2 strobe, busy=0.
   - rx low pulse of 4 cycles -> ignored, no pulses.
